// File: rtl/proc_isa_pkg.sv
// Shared ISA definitions for the proc processor: opcodes, instruction field slices,
// the default halt word and the sequencer state encoding.
package proc_isa_pkg;

  localparam int WORD_W = 9;
  typedef logic [WORD_W-1:0] word_t;
  typedef logic [2:0]        opcode_t;
  typedef logic [2:0]        reg_idx_t;

  localparam opcode_t OP_MV  = 3'b000;
  localparam opcode_t OP_MVI = 3'b001;
  localparam opcode_t OP_ADD = 3'b010;
  localparam opcode_t OP_SUB = 3'b011;

  // Instruction word layout is IIIXXXYYY.
  localparam int OP_MSB = 8;
  localparam int OP_LSB = 6;
  localparam int X_MSB  = 5;
  localparam int X_LSB  = 3;
  localparam int Y_MSB  = 2;
  localparam int Y_LSB  = 0;

  localparam word_t DEFAULT_HALT_WORD = 9'h1FF;

  typedef enum logic [2:0] {
    SEQ_IDLE,
    SEQ_FETCH,
    SEQ_DECODE,
    SEQ_ISSUE,
    SEQ_WAIT,
    SEQ_HALTED,
    SEQ_ERROR
  } seq_state_e;

  function automatic opcode_t op_field(input word_t w);
    return w[OP_MSB:OP_LSB];
  endfunction

  function automatic reg_idx_t x_field(input word_t w);
    return w[X_MSB:X_LSB];
  endfunction

  function automatic reg_idx_t y_field(input word_t w);
    return w[Y_MSB:Y_LSB];
  endfunction

  function automatic logic seq_busy(input seq_state_e s);
    return s inside {SEQ_FETCH, SEQ_DECODE, SEQ_ISSUE, SEQ_WAIT};
  endfunction

endpackage

// File: rtl/done_watchdog.sv
// Clearable up-counter that bounds how long the sequencer waits for Done.
module done_watchdog #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && count != CNT_W'(TIMEOUT)) begin
      count <= count + CNT_W'(1);
    end
  end

  // Asserted while the pending increment would reach TIMEOUT, so the owner can
  // leave WAIT on the very edge where the limit is hit.
  assign expired = (count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/proc_inst_sequencer.sv
// Fetches IIIXXXYYY words from a synchronous ROM and issues them to proc with a
// one-cycle Run pulse, supplying the mvi immediate and waiting for Done.
module proc_inst_sequencer
  import proc_isa_pkg::*;
#(
  parameter int    ADDR_W    = 5,
  parameter word_t HALT_WORD = DEFAULT_HALT_WORD,
  parameter int    TIMEOUT   = 16
) (
  input  logic              CLOCK_50,
  input  logic              Resetn,
  input  logic              Start,
  input  logic              Done,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [8:0]        mem_data,
  output logic [8:0]        Instruction,
  output logic              Run,
  output logic              Busy,
  output logic              Halted,
  output logic              Error
);

  seq_state_e        state, state_next;
  logic [ADDR_W-1:0] pc, pc_next;
  word_t             instr_next;
  logic              run_next;
  logic              wd_clr, wd_inc, wd_expired;

  done_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk     (CLOCK_50),
    .rst_n   (Resetn),
    .clr     (wd_clr),
    .inc     (wd_inc),
    .expired (wd_expired)
  );

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    pc_next    = pc;
    instr_next = Instruction;
    run_next   = 1'b0;
    wd_clr     = 1'b0;
    wd_inc     = 1'b0;
    mem_addr   = pc;

    unique case (state)
      SEQ_IDLE, SEQ_HALTED, SEQ_ERROR: begin
        if (Start) begin
          state_next = SEQ_FETCH;
          pc_next    = '0;
        end
      end
      SEQ_FETCH: state_next = SEQ_DECODE;
      SEQ_DECODE: begin
        // Prefetch the following word: it is the immediate if this is an mvi.
        mem_addr = pc + ADDR_W'(1);
        if (mem_data == HALT_WORD) begin
          state_next = SEQ_HALTED;
        end else begin
          instr_next = mem_data;
          run_next   = 1'b1;
          state_next = SEQ_ISSUE;
        end
      end
      SEQ_ISSUE: begin
        wd_clr = 1'b1;
        if (op_field(Instruction) == OP_MVI) begin
          instr_next = mem_data;
          pc_next    = pc + ADDR_W'(2);
        end else begin
          pc_next    = pc + ADDR_W'(1);
        end
        state_next = SEQ_WAIT;
      end
      SEQ_WAIT: begin
        if (Done) begin
          state_next = SEQ_FETCH;
        end else if (wd_expired) begin
          state_next = SEQ_ERROR;
        end else begin
          wd_inc = 1'b1;
        end
      end
      default: state_next = SEQ_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      state       <= SEQ_IDLE;
      pc          <= '0;
      Instruction <= '0;
      Run         <= 1'b0;
      Busy        <= 1'b0;
      Halted      <= 1'b0;
      Error       <= 1'b0;
    end else begin
      state       <= state_next;
      pc          <= pc_next;
      Instruction <= instr_next;
      Run         <= run_next;
      Busy        <= seq_busy(state_next);
      Halted      <= (state_next == SEQ_HALTED);
      Error       <= (state_next == SEQ_ERROR);
    end
  end

endmodule

// File: tb/tb_proc_inst_sequencer.sv
// Self-checking bench for proc_inst_sequencer: cycle table, directed corner cases,
// and random programs checked against a program-level reference model.
module tb_proc_inst_sequencer;
  import proc_isa_pkg::*;

  localparam int AW    = 5;
  localparam int DEPTH = 32;
  localparam int TO    = 16;
  localparam logic [8:0] HALT = 9'h1FF;

  logic          clk, rst_n, start, done_man, done_auto, use_auto, done_sig;
  logic [AW-1:0] mem_addr;
  logic [8:0]    mem_data, instruction;
  logic          run, busy, halted, error;

  logic [8:0] rom [DEPTH];
  logic [8:0] act_trace[$];
  logic [8:0] exp_trace[$];

  int errors = 0;
  int checks = 0;
  int lat_fixed, run_cycles, run_overlap, wait_cnt, cur_lat;
  bit pending, need_imm, prev_run;

  typedef struct {
    logic          start;
    logic          done;
    logic          exp_run;
    logic          exp_busy;
    logic          exp_halted;
    logic          exp_error;
    logic [AW-1:0] exp_addr;
    logic [8:0]    exp_instr;
  } vec_t;

  vec_t vecs[11];

  proc_inst_sequencer #(.ADDR_W(AW), .HALT_WORD(HALT), .TIMEOUT(TO)) dut (
    .CLOCK_50    (clk),
    .Resetn      (rst_n),
    .Start       (start),
    .Done        (done_sig),
    .mem_addr    (mem_addr),
    .mem_data    (mem_data),
    .Instruction (instruction),
    .Run         (run),
    .Busy        (busy),
    .Halted      (halted),
    .Error       (error)
  );

  assign done_sig = use_auto ? done_auto : done_man;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) mem_data <= rom[mem_addr];

  // proc stand-in: records issued words and answers Done after a latency.
  initial begin
    done_auto = 1'b0; pending = 0; need_imm = 0; prev_run = 0;
    run_cycles = 0; run_overlap = 0; wait_cnt = 0; cur_lat = 0;
    forever begin
      @(negedge clk);
      done_auto = 1'b0;
      if (!rst_n) begin
        pending = 0; need_imm = 0; prev_run = 0;
      end else begin
        if (run && prev_run) run_overlap++;
        prev_run = run;
        if (run) begin
          run_cycles++;
          act_trace.push_back(instruction);
          need_imm = (op_field(instruction) == OP_MVI);
          pending  = 1;
          wait_cnt = 0;
          cur_lat  = (lat_fixed >= 0) ? lat_fixed : int'($urandom_range(0, 4));
        end else if (pending) begin
          if (need_imm) begin
            act_trace.push_back(instruction);
            need_imm = 0;
          end
          if (wait_cnt == cur_lat) begin
            done_auto = 1'b1;
            pending   = 0;
          end
          wait_cnt++;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete, required completion");
    $fatal(1);
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    act_trace.delete();
    run_cycles  = 0;
    run_overlap = 0;
  endtask

  task automatic fill_rom(input logic [8:0] w);
    for (int a = 0; a < DEPTH; a++) rom[a] = w;
  endtask

  // Program-level reference: walk the ROM by the ISA rules, no cycle timing.
  task automatic model_run(input int max_len, output int end_pc, output bit did_halt);
    int pc;
    pc = 0;
    did_halt = 0;
    exp_trace.delete();
    while (exp_trace.size() < max_len) begin
      if (rom[pc] == HALT) begin
        did_halt = 1;
        break;
      end
      exp_trace.push_back(rom[pc]);
      if (op_field(rom[pc]) == OP_MVI) begin
        exp_trace.push_back(rom[(pc + 1) % DEPTH]);
        pc = (pc + 2) % DEPTH;
      end else begin
        pc = (pc + 1) % DEPTH;
      end
    end
    end_pc = pc;
  endtask

  task automatic compare_trace(input string tag);
    check({tag, "_len"}, 32'(act_trace.size()), 32'(exp_trace.size()));
    for (int i = 0; i < act_trace.size() && i < exp_trace.size(); i++)
      check($sformatf("%s_w%0d", tag, i), 32'(act_trace[i]), 32'(exp_trace[i]));
  endtask

  task automatic exec_r0(output logic [8:0] r0);
    logic [8:0] r [8];
    logic [8:0] w;
    int i;
    for (int k = 0; k < 8; k++) r[k] = '0;
    i = 0;
    while (i < act_trace.size()) begin
      w = act_trace[i];
      case (op_field(w))
        OP_MV:  r[x_field(w)] = r[y_field(w)];
        OP_MVI: begin
          if (i + 1 < act_trace.size()) r[x_field(w)] = act_trace[i + 1];
          i++;
        end
        OP_ADD: r[x_field(w)] = r[x_field(w)] + r[y_field(w)];
        OP_SUB: r[x_field(w)] = r[x_field(w)] - r[y_field(w)];
        default: ;
      endcase
      i++;
    end
    r0 = r[0];
  endtask

  task automatic wait_run(input int budget, output bit ok);
    ok = 0;
    for (int c = 0; c < budget; c++) begin
      if (run === 1'b1) begin
        ok = 1;
        break;
      end
      tick();
    end
  endtask

  task automatic run_until_halt(input int budget, input bit toggle, output bit ok, output bit saw_err);
    ok = 0;
    saw_err = 0;
    for (int c = 0; c < budget; c++) begin
      if (toggle) start = 1'($urandom_range(0, 1));
      tick();
      if (error) saw_err = 1;
      if (halted) begin
        ok = 1;
        break;
      end
    end
    start = 1'b0;
  endtask

  initial begin
    bit         ok, saw_err, did_halt, any_run;
    int         end_pc, h;
    logic [8:0] r0;
    logic [2:0] op;

    rst_n = 1'b0; start = 1'b0; done_man = 1'b0; use_auto = 1'b0; lat_fixed = -1;
    fill_rom(HALT);
    repeat (2) tick();

    check("reset_run",    32'(run),         32'(0));
    check("reset_instr",  32'(instruction), 32'(0));
    check("reset_addr",   32'(mem_addr),    32'(0));
    check("reset_busy",   32'(busy),        32'(0));
    check("reset_halted", 32'(halted),      32'(0));
    check("reset_error",  32'(error),       32'(0));
    rst_n = 1'b1;
    tick();

    // Cycle table: mv then halt, Start while busy, Done outside WAIT, restart from HALTED.
    rom[0] = 9'o010;
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 9'o000};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd1, 9'o000};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 9'o010};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd1, 9'o010};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd1, 9'o010};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd2, 9'o010};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd1, 9'o010};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd1, 9'o010};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 9'o010};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd1, 9'o010};
    vecs[10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 9'o010};
    for (int i = 0; i < 11; i++) begin
      start    = vecs[i].start;
      done_man = vecs[i].done;
      tick();
      check($sformatf("vec%0d", i),
            32'({run, busy, halted, error, mem_addr, instruction}),
            32'({vecs[i].exp_run, vecs[i].exp_busy, vecs[i].exp_halted, vecs[i].exp_error,
                 vecs[i].exp_addr, vecs[i].exp_instr}));
    end
    start = 1'b0; done_man = 1'b0;
    use_auto = 1'b1;
    apply_reset();

    // Reference program: mvi R0,5; mv R1,R0; add R0,R1; halt.
    fill_rom(HALT);
    rom[0] = 9'o100; rom[1] = 9'o005; rom[2] = 9'o010; rom[3] = 9'o201;
    pulse_start();
    run_until_halt(300, 1'b0, ok, saw_err);
    check("prog_halted", 32'(ok), 32'(1));
    check("prog_runs", 32'(run_cycles), 32'(3));
    check("prog_run_width", 32'(run_overlap), 32'(0));
    check("prog_imm", 32'((act_trace.size() > 1) ? act_trace[1] : 9'h0), 32'(9'o005));
    check("prog_halt_pc", 32'(mem_addr), 32'(4));
    exec_r0(r0);
    check("prog_r0", 32'(r0), 32'(10));
    model_run(64, end_pc, did_halt);
    compare_trace("prog");

    // Done never arrives: Error exactly TIMEOUT cycles after entering WAIT.
    apply_reset();
    fill_rom(HALT);
    rom[0] = 9'o201;
    lat_fixed = 1000;
    pulse_start();
    wait_run(10, ok);
    check("to_run_seen", 32'(ok), 32'(1));
    for (int k = 0; k < TO; k++) tick();
    check("to_before", 32'({busy, error}), 32'(2'b10));
    tick();
    check("to_error", 32'({busy, halted, error}), 32'(3'b001));
    any_run = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (run) any_run = 1;
    end
    check("to_run_quiet", 32'(any_run), 32'(0));
    pulse_start();
    check("to_restart", 32'({busy, error, mem_addr}), 32'({1'b1, 1'b0, 5'd0}));

    // Done on the timeout cycle wins.
    apply_reset();
    fill_rom(HALT);
    rom[0] = 9'o201; rom[1] = 9'o310;
    lat_fixed = TO - 1;
    pulse_start();
    run_until_halt(200, 1'b0, ok, saw_err);
    check("edge_halted", 32'(ok), 32'(1));
    check("edge_no_error", 32'(saw_err), 32'(0));
    check("edge_halt_pc", 32'(mem_addr), 32'(2));
    model_run(64, end_pc, did_halt);
    compare_trace("edge");

    // mvi at the last address wraps; then reset during WAIT of an add.
    apply_reset();
    lat_fixed = 1;
    rom[0]  = 9'o007;
    rom[1]  = 9'o201;
    for (int a = 2; a < DEPTH - 1; a++) begin
      case ($urandom_range(0, 2))
        0:       op = OP_MV;
        1:       op = OP_ADD;
        default: op = OP_SUB;
      endcase
      rom[a] = {op, 6'($urandom)};
    end
    rom[DEPTH-1] = 9'o130;
    pulse_start();
    ok = 0;
    for (int c = 0; c < 600; c++) begin
      if (act_trace.size() >= 34) begin
        ok = 1;
        break;
      end
      tick();
    end
    check("wrap_progress", 32'(ok), 32'(1));
    check("wrap_issue_pc", 32'(mem_addr), 32'(1));
    model_run(34, end_pc, did_halt);
    compare_trace("wrap");
    tick();
    check("wrap_in_wait", 32'({busy, run}), 32'(2'b10));
    rst_n = 1'b0;
    #1;
    check("async_reset", 32'({run, busy, halted, error, mem_addr, instruction}), 32'(0));
    tick();
    rst_n = 1'b1;
    act_trace.delete();
    lat_fixed = -1;
    tick();
    pulse_start();
    check("refetch_addr", 32'({busy, mem_addr}), 32'({1'b1, 5'd0}));
    wait_run(10, ok);
    check("refetch_run", 32'(ok), 32'(1));
    check("refetch_word", 32'(instruction), 32'(9'o007));
    apply_reset();

    // Random programs, random Done latency, Start toggled while busy,
    // restarted from HALTED without reset.
    lat_fixed = -1;
    for (int t = 0; t < 6; t++) begin
      h = $urandom_range(4, 28);
      for (int a = 0; a < DEPTH; a++) begin
        if (a < h) rom[a] = {3'($urandom_range(0, 3)), 6'($urandom)};
        else       rom[a] = 9'($urandom);
      end
      rom[h] = HALT;
      rom[h+1] = HALT;
      act_trace.delete();
      pulse_start();
      run_until_halt(3000, 1'b1, ok, saw_err);
      check($sformatf("rnd%0d_halted", t), 32'(ok), 32'(1));
      check($sformatf("rnd%0d_no_error", t), 32'(saw_err), 32'(0));
      model_run(200, end_pc, did_halt);
      check($sformatf("rnd%0d_pc", t), 32'(mem_addr), 32'(end_pc));
      compare_trace($sformatf("rnd%0d", t));
    end
    check("rnd_run_width", 32'(run_overlap), 32'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
